stopwatch_ctrl: RTL and testbench
=================================

// Module: stopwatch_ctrl
// PURPOSE
//   Run/pause/adjust sequencer for the 4-digit stopwatch datapath. Conditions btnS/btnR,
//   runs the stopwatch mode FSM, and issues single-cycle enables to the time counters
//   (count, adjust, clear), plus display blink and digit-scan strobes.
//   Sits between board I/O (buttons, sw) and the counter/7-seg display blocks.
// PARAMETERS
//   DIV_1HZ    100_000_000  clk cycles per counted second (1 Hz time base)
//   DIV_2HZ    50_000_000   clk cycles per adjust/blink tick (2 Hz)
//   DIV_SCAN   100_000      clk cycles per display digit-scan strobe
//   DB_CYCLES  1_000_000    consecutive stable cycles needed to accept a button level
// PORTS
//   clk        in   1  system clock, all logic on rising edge
//   rst        in   1  asynchronous, active-low reset
//   btnS       in   1  raw pause/run button, async to clk
//   btnR       in   1  raw stopwatch-clear button, async to clk (NOT a logic reset)
//   sw         in   2  sw[0]=adjust mode, sw[1]=adjust target (0 seconds, 1 minutes)
//   cnt_en     out  1  1-cycle pulse: advance time by one second
//   adj_en     out  1  1-cycle pulse: increment selected field by one
//   adj_sel    out  1  adjust target, registered copy of sw[1]
//   clr        out  1  1-cycle pulse: zero the time counters
//   blink      out  1  selected-field blink level in ADJUST, 0 otherwise
//   scan_tick  out  1  1-cycle pulse: advance display anode index
//   state      out  2  FSM state (00 IDLE, 01 RUN, 10 PAUSED, 11 ADJUST)
// BEHAVIOUR
//   Reset (rst=0): immediate, no clock needed. state=IDLE; all outputs, divider
//     counters, synchronizers, debounced levels = 0.
//   Buttons: 2-flop sync each; debounced level flips after sync value differs from it
//     for DB_CYCLES consecutive cycles (mismatch counter clears on any match). Rising
//     edge of debounced level = one-cycle event. Press->event latency 2+DB_CYCLES+1 clk.
//   Dividers: counter 0..DIV-1, terminal count (TC) at DIV-1, then wraps to 0.
//     scan and 2 Hz dividers free-run. 1 Hz divider counts only in RUN, holds value in
//     other states (sub-second fraction preserved), forced to 0 on a btnR event.
//   FSM next state, priority top-down, evaluated each cycle:
//     1. btnR event           -> clr=1 next cycle; IDLE (ADJUST if sw[0]=1)
//     2. sw[0]=1              -> ADJUST (from any state)
//     3. ADJUST and sw[0]=0   -> PAUSED
//     4. btnS event: IDLE->RUN, RUN->PAUSED, PAUSED->RUN
//     5. otherwise hold
//   btnS and btnR events in same cycle: btnR wins, btnS dropped (no toggle).
//   All outputs registered, 1 clk after cause:
//     cnt_en = 1Hz TC while state==RUN (TC on the cycle RUN is left still pulses once)
//     adj_en = 2Hz TC while state==ADJUST; adj_sel = sw[1] every cycle
//     blink toggles on each 2Hz TC while ADJUST; forced 0 outside ADJUST
//     scan_tick = scan TC, always, independent of state
//   cnt_en and adj_en never high together; clr may coincide with neither.
//   Entering RUN from IDLE after clear: first cnt_en exactly DIV_1HZ clk after entry.
// TESTING (bench params: DIV_1HZ=10, DIV_2HZ=5, DIV_SCAN=4, DB_CYCLES=3)
//   Hold rst=0, toggle buttons/sw -> state=00, all outputs 0; release, idle 100 clk ->
//     no cnt_en/adj_en/clr, scan_tick every 4 clk.
//   btnS high 8 clk -> state 01 six clk after press; cnt_en every 10 clk; 2-clk btnS
//     glitch -> ignored, state unchanged.
//   RUN, pause when 1Hz count=4, wait 50 clk, resume -> no cnt_en while PAUSED; first
//     cnt_en 6 clk after re-entering RUN.
//   RUN, set sw=2'b11 -> state 11 next clk, cnt_en stops, adj_en every 5 clk, adj_sel=1,
//     blink toggles every 5 clk; sw=2'b00 -> state 10, blink=0.
//   RUN, btnS and btnR pressed together -> single clr pulse, state 00, 1Hz count 0,
//     no extra toggle.
//   Drop rst mid-RUN between clk edges -> state/outputs 0 before next rising edge.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: run/pause/adjust sequencer issuing counter enables, clear, blink and scan strobes
module stopwatch_ctrl #(
    parameter int DIV_1HZ   = 100_000_000,
    parameter int DIV_2HZ   = 50_000_000,
    parameter int DIV_SCAN  = 100_000,
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btnS,
    input  logic       btnR,
    input  logic [1:0] sw,
    output logic       cnt_en,
    output logic       adj_en,
    output logic       adj_sel,
    output logic       clr,
    output logic       blink,
    output logic       scan_tick,
    output logic [1:0] state
);
    typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PAUSED = 2'b10, ADJUST = 2'b11} state_t;

    localparam int W1 = $clog2(DIV_1HZ + 1);
    localparam int W2 = $clog2(DIV_2HZ + 1);
    localparam int WS = $clog2(DIV_SCAN + 1);
    localparam int WD = $clog2(DB_CYCLES + 1);
    localparam logic [W1-1:0] TC1 = W1'(DIV_1HZ - 1);
    localparam logic [W2-1:0] TC2 = W2'(DIV_2HZ - 1);
    localparam logic [WS-1:0] TCS = WS'(DIV_SCAN - 1);
    localparam logic [WD-1:0] DBT = WD'(DB_CYCLES - 1);

    // bit 0 tracks btnS, bit 1 tracks btnR
    logic [1:0] sync1_q, sync1_d, sync2_q, sync2_d, db_q, db_d, dbp_q, dbp_d;
    logic [1:0][WD-1:0] dbc_q, dbc_d;
    logic [W1-1:0] div1_q, div1_d;
    logic [W2-1:0] div2_q, div2_d;
    logic [WS-1:0] divs_q, divs_d;
    state_t state_q, state_d;
    logic cnt_en_q, cnt_en_d, adj_en_q, adj_en_d, adj_sel_q, adj_sel_d;
    logic clr_q, clr_d, blink_q, blink_d, scan_q, scan_d;
    logic s_ev, r_ev, tc1, tc2, tcs;

    assign s_ev = db_q[0] & ~dbp_q[0];
    assign r_ev = db_q[1] & ~dbp_q[1];
    assign tc1  = div1_q == TC1;
    assign tc2  = div2_q == TC2;
    assign tcs  = divs_q == TCS;

    // synchronize buttons; a level is accepted only after DB_CYCLES straight mismatches
    always_comb begin
        sync1_d = {btnR, btnS};
        sync2_d = sync1_q;
        dbp_d   = db_q;
        dbc_d   = '0;
        db_d    = db_q;
        for (int i = 0; i < 2; i++) begin
            dbc_d[i] = (sync2_q[i] == db_q[i] || dbc_q[i] == DBT) ? '0 : dbc_q[i] + 1'b1;
            db_d[i]  = (sync2_q[i] != db_q[i] && dbc_q[i] == DBT) ? ~db_q[i] : db_q[i];
        end
    end

    // 1 Hz base keeps its sub-second fraction outside RUN; the other dividers free-run
    always_comb begin
        div1_d = r_ev ? '0 : (state_q != RUN) ? div1_q : tc1 ? '0 : div1_q + 1'b1;
        div2_d = tc2 ? '0 : div2_q + 1'b1;
        divs_d = tcs ? '0 : divs_q + 1'b1;
    end

    // mode FSM with clear taking priority over adjust, adjust over run/pause toggling
    always_comb begin
        state_d = state_q;
        if (r_ev)
            state_d = sw[0] ? ADJUST : IDLE;
        else if (sw[0])
            state_d = ADJUST;
        else if (state_q == ADJUST)
            state_d = PAUSED;
        else if (s_ev)
            state_d = (state_q == RUN) ? PAUSED : RUN;
        cnt_en_d  = tc1 && state_q == RUN && !r_ev;
        adj_en_d  = tc2 && state_q == ADJUST && !r_ev;
        adj_sel_d = sw[1];
        clr_d     = r_ev;
        blink_d   = (state_q == ADJUST) && (blink_q ^ tc2);
        scan_d    = tcs;
    end

    // all state and registered outputs, cleared immediately by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            db_q      <= '0;
            dbp_q     <= '0;
            dbc_q     <= '0;
            div1_q    <= '0;
            div2_q    <= '0;
            divs_q    <= '0;
            state_q   <= IDLE;
            cnt_en_q  <= 1'b0;
            adj_en_q  <= 1'b0;
            adj_sel_q <= 1'b0;
            clr_q     <= 1'b0;
            blink_q   <= 1'b0;
            scan_q    <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            db_q      <= db_d;
            dbp_q     <= dbp_d;
            dbc_q     <= dbc_d;
            div1_q    <= div1_d;
            div2_q    <= div2_d;
            divs_q    <= divs_d;
            state_q   <= state_d;
            cnt_en_q  <= cnt_en_d;
            adj_en_q  <= adj_en_d;
            adj_sel_q <= adj_sel_d;
            clr_q     <= clr_d;
            blink_q   <= blink_d;
            scan_q    <= scan_d;
        end
    end

    assign cnt_en    = cnt_en_q;
    assign adj_en    = adj_en_q;
    assign adj_sel   = adj_sel_q;
    assign clr       = clr_q;
    assign blink     = blink_q;
    assign scan_tick = scan_q;
    assign state     = state_q;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: directed and random stimulus checked against a behavioural stopwatch model
module tb_stopwatch_ctrl;
    localparam int D1 = 10, D2 = 5, DS = 4, DB = 3;
    localparam int IDLE = 0, RUN = 1, PAUSED = 2, ADJUST = 3;

    logic clk = 1'b0, rst = 1'b0, btnS = 1'b0, btnR = 1'b0;
    logic [1:0] sw = 2'b00;
    logic cnt_en, adj_en, adj_sel, clr, blink, scan_tick;
    logic [1:0] state;
    int n_assert = 0, n_fail = 0;

    int n, mstate, frac;
    bit blk, e_cnt, e_adj, e_sel, e_clr, e_scan;
    bit [1:0] db, dbp;
    logic [1:0] raw_hist[$];
    logic [1:0] smp_hist[$];

    stopwatch_ctrl #(.DIV_1HZ(D1), .DIV_2HZ(D2), .DIV_SCAN(DS), .DB_CYCLES(DB)) dut (
        .clk(clk), .rst(rst), .btnS(btnS), .btnR(btnR), .sw(sw),
        .cnt_en(cnt_en), .adj_en(adj_en), .adj_sel(adj_sel), .clr(clr),
        .blink(blink), .scan_tick(scan_tick), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".state"}, state, 0);
        chk({tag, ".cnt_en"}, cnt_en, 0);
        chk({tag, ".adj_en"}, adj_en, 0);
        chk({tag, ".adj_sel"}, adj_sel, 0);
        chk({tag, ".clr"}, clr, 0);
        chk({tag, ".blink"}, blink, 0);
        chk({tag, ".scan"}, scan_tick, 0);
    endtask

    task automatic model_reset();
        n = 0; mstate = IDLE; frac = 0; blk = 0; db = 0; dbp = 0;
        e_cnt = 0; e_adj = 0; e_sel = 0; e_clr = 0; e_scan = 0;
        raw_hist = {2'b00, 2'b00};
        smp_hist = {};
    endtask

    // one rising edge of the reference: outputs from pre-edge values, then advance
    task automatic model_edge();
        bit [1:0] ev, flip;
        bit tc2, all;
        int ns;
        ev  = db & ~dbp;
        tc2 = (n % D2) == D2 - 1;
        e_cnt  = mstate == RUN && frac == D1 - 1 && !ev[1];
        e_adj  = mstate == ADJUST && tc2 && !ev[1];
        e_sel  = sw[1];
        e_clr  = ev[1];
        e_scan = (n % DS) == DS - 1;
        blk  = (mstate == ADJUST) ? blk ^ tc2 : 1'b0;
        frac = ev[1] ? 0 : (mstate == RUN) ? (frac + 1) % D1 : frac;
        if (ev[1]) ns = sw[0] ? ADJUST : IDLE;
        else if (sw[0]) ns = ADJUST;
        else if (mstate == ADJUST) ns = PAUSED;
        else if (ev[0]) ns = (mstate == RUN) ? PAUSED : RUN;
        else ns = mstate;
        mstate = ns;
        smp_hist.push_back(raw_hist[$-1]);
        if (smp_hist.size() > DB) void'(smp_hist.pop_front());
        raw_hist.push_back({btnR, btnS});
        if (raw_hist.size() > 4) void'(raw_hist.pop_front());
        for (int i = 0; i < 2; i++) begin
            all = smp_hist.size() == DB;
            foreach (smp_hist[j]) if (smp_hist[j][i] == db[i]) all = 0;
            flip[i] = all;
        end
        dbp = db;
        db  = db ^ flip;
        n++;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        chk("state", state, mstate);
        chk("cnt_en", cnt_en, e_cnt);
        chk("adj_en", adj_en, e_adj);
        chk("adj_sel", adj_sel, e_sel);
        chk("clr", clr, e_clr);
        chk("blink", blink, blk);
        chk("scan_tick", scan_tick, e_scan);
    endtask

    task automatic steps(input int k);
        for (int i = 0; i < k; i++) step();
    endtask

    initial begin
        int cs, ca, cc, got, tog;
        logic pb;
        for (int i = 0; i < 6; i++) begin
            btnS = i[0]; btnR = i[1]; sw = 2'(i);
            @(posedge clk);
            #1;
            chk_zero("rst_hold");
        end
        btnS = 0; btnR = 0; sw = 0;
        model_reset();
        rst = 1;
        cs = 0; ca = 0; cc = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            cs += int'(scan_tick); ca += int'(cnt_en) + int'(adj_en); cc += int'(clr);
        end
        chk("idle_scan_cnt", cs, 25);
        chk("idle_en_cnt", ca, 0);
        chk("idle_clr_cnt", cc, 0);

        btnS = 1;
        for (int i = 1; i <= 8; i++) begin
            step();
            if (i == 5) chk("start_lat5", state, IDLE);
            if (i == 6) chk("start_lat6", state, RUN);
        end
        btnS = 0;
        ca = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            ca += int'(cnt_en);
        end
        chk("run_cnt_en_30", ca, 3);
        btnS = 1; steps(2); btnS = 0; steps(10);
        chk("glitch_ignored", state, RUN);

        for (int k = 0; k < 20 && frac != 8; k++) step();
        btnS = 1; steps(5); btnS = 0; steps(50);
        chk("paused", state, PAUSED);
        btnS = 1; got = -1;
        for (int k = 1; k <= 40; k++) begin
            if (k == 6) btnS = 0;
            step();
            if (cnt_en) begin got = k; break; end
        end
        btnS = 0;
        chk("resume_latency", got, 12);

        sw = 2'b11;
        step();
        chk("adjust_enter", state, ADJUST);
        ca = 0; tog = 0; pb = blink;
        for (int i = 0; i < 20; i++) begin
            step();
            ca += int'(adj_en); tog += int'(blink != pb); pb = blink;
        end
        chk("adj_en_20", ca, 4);
        chk("blink_tog_20", tog, 4);
        chk("adj_sel_hi", adj_sel, 1);
        sw = 2'b00;
        step();
        chk("adjust_exit", state, PAUSED);
        step();
        chk("blink_off", blink, 0);

        btnS = 1; steps(5); btnS = 0; steps(10);
        chk("rerun", state, RUN);
        btnS = 1; btnR = 1; cc = 0;
        for (int k = 1; k <= 25; k++) begin
            if (k == 6) begin btnS = 0; btnR = 0; end
            step();
            cc += int'(clr);
        end
        chk("clr_pulses", cc, 1);
        chk("clr_state", state, IDLE);
        btnS = 1; got = -1;
        for (int k = 1; k <= 40; k++) begin
            if (k == 6) btnS = 0;
            step();
            if (cnt_en) begin got = k; break; end
        end
        btnS = 0;
        chk("fresh_run_latency", got, 16);

        for (int s = 0; s < 40; s++) begin
            btnS = $urandom_range(0, 3) == 0;
            btnR = $urandom_range(0, 7) == 0;
            sw = ($urandom_range(0, 5) == 0) ? 2'($urandom) : {1'($urandom), 1'b0};
            steps($urandom_range(1, 10));
        end

        btnS = 0; btnR = 0; sw = 0;
        steps(10);
        for (int t = 0; t < 3 && mstate != RUN; t++) begin
            btnS = 1; steps(5); btnS = 0; steps(10);
        end
        chk("run_before_rst", state, RUN);
        steps(3);
        #2 rst = 0;
        #1 chk_zero("async_rst");
        model_reset();
        @(posedge clk);
        #1;
        chk_zero("rst_held_edge");
        rst = 1;
        steps(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
